ram_latency_model: RTL and testbench
====================================

# ram_latency_model

Synthesizable word-addressed RAM responder that sits on the RAM side of the memory controller. It serves the `ramREN`/`ramWEN`/`ramaddr`/`ramstore` requests the controller issues and answers through `ramstate` and `ramload`. It has a configurable access latency, so controller and cache arbitration can be exercised against slow memory. It also raises `ERROR` on malformed requests.

## Interface
- `LAT`, default 2: wait cycles spent in `BUSY` before `ACCESS` (0..15); 0 means the access happens on the cycle after the request.
- `DEPTH`, default 4096: number of 32-bit words of storage; power of two.
- `CLK` in 1: single clock, rising edge.
- `nRST` in 1: reset, asynchronous, active-low.
- `ramaddr` in 32 (`word_t`): byte address of the request.
- `ramstore` in 32 (`word_t`): write data.
- `ramREN` in 1: read request, level-held until `ACCESS`.
- `ramWEN` in 1: write request, level-held until `ACCESS`.
- `ramload` out 32 (`word_t`): read data, registered.
- `ramstate` out 2 (`ramstate_t`): `FREE`, `BUSY`, `ACCESS` or `ERROR`, registered.

## Operation
- States are `FREE`, `BUSY`, `ACCESS` and `ERROR`. `ramstate` equals the state register.
- A request is active when `ramREN | ramWEN`.
- A request is malformed if any of these holds:
  - `ramREN & ramWEN`
  - `ramaddr[1:0] != 0`
  - `ramaddr[31:2] >= DEPTH`
- On each edge in `FREE`, or in the cycle after `ACCESS`, the next state is chosen as follows:
  - No request: go to `FREE`.
  - Malformed request: go to `ERROR`.
  - `LAT == 0`: go to `ACCESS`.
  - Otherwise: go to `BUSY`, load the counter with `LAT`, and latch `ramaddr`, `ramREN`, `ramWEN` and `ramstore` into the request register.
- `BUSY` behaviour on each edge:
  - Request dropped: go to `FREE`, with no memory side effect.
  - Any input differs from the latched request (address, REN, WEN, or store data while writing): restart by reloading the counter with `LAT` and re-latching. If the new request is malformed, go to `ERROR`.
  - Otherwise decrement the counter. The edge where the counter equals 1 moves to `ACCESS`.
- `ACCESS` lasts exactly one cycle.
  - For a read, `ramload` is loaded with `mem[ramaddr[31:2]]` on the edge that enters `ACCESS`, so the data is valid throughout the `ACCESS` cycle.
  - For a write, `mem` is updated on the edge that leaves `ACCESS`.
  - The next state is evaluated as from `FREE`. A request still held after `ACCESS` therefore starts a new transaction, and a held write repeats, which is idempotent.
- `ERROR` holds while a malformed request persists.
  - A dropped request goes to `FREE`.
  - A well-formed request is handled as from `FREE`.
  - `ERROR` never modifies memory or `ramload`.
- `ramload` holds its last read value outside read accesses.
- Storage width is `$clog2(DEPTH)` index bits. Address bits above the index are checked only for the range error.

## Timing
- Reset values: `ramstate = FREE`, `ramload = 0`, counter 0, latched request cleared.
- Memory contents are not reset; they are undefined at power-up and preserved across `nRST`.
- Read latency: a request first seen in cycle t produces `ACCESS` with valid `ramload` in cycle t+`LAT`+1.
- Write latency: the write is visible to a read whose `ACCESS` falls in cycle t+`LAT`+2 or later.
- Handshake: the requester must hold its inputs stable until it observes `ACCESS`. Any change restarts the full latency.
- Reset mid-`BUSY` or mid-`ACCESS` aborts the transaction. A pending write is not committed unless the edge leaving `ACCESS` precedes the `nRST` assertion.

## Structure
- `ramstate_t` (`FREE`, `BUSY`, `ACCESS`, `ERROR`) and `word_t` come from `cpu_types_pkg`. No new typedefs.
- The `LAT` counter width is a localparam of 4 bits.
- Sub-module `ram_array`: single-port `DEPTH`×32 storage with a synchronous write enable and a synchronous read-to-register path. It is instantiated once.
- FSM, request latch, counter and malformed-request checks live in the top module.

## Test plan
- **Write then read, `LAT=2`:**
  - Write `ramaddr=0x00000010`, `ramstore=0xDEADBEEF`, held 4 cycles: `ramstate` goes `FREE`→`BUSY`→`BUSY`→`ACCESS`.
  - Read of the same address: `ACCESS` in the 3rd cycle after the request with `ramload=0xDEADBEEF`.
- **`LAT=0` back-to-back reads:**
  - Read 0x0 is held two cycles while `mem[0]=0x11111111`: `ACCESS` on consecutive cycles, `ramload=0x11111111` both times.
- **Restart mid-`BUSY`:**
  - With `LAT=3`, the read address changes from 0x20 to 0x24 after 2 cycles.
  - Required: `ACCESS` arrives 4 cycles after the change and `ramload` equals `mem[9]`, not `mem[8]`.
- **Drop mid-`BUSY`:**
  - A write to 0x30 of 0xCAFEF00D is deasserted after 1 cycle: state returns to `FREE`.
  - A later read of 0x30 returns the old value.
- **Errors:**
  - `ramREN=ramWEN=1`: `ERROR`.
  - `ramaddr=0x00000002`: `ERROR`.
  - `ramaddr=4*DEPTH`: `ERROR`.
  - In each case the state returns to `FREE` one edge after the request drops, and memory and `ramload` are unchanged.
- **Async reset in `BUSY`:**
  - `nRST` is asserted mid-cycle: `ramstate=FREE` and `ramload=0` immediately, without a clock edge.
  - Previously written words are still readable after reset.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared CPU/memory types used by the RAM responder and its clients.
//   word_t     : 32-bit machine word (addresses and data)
//   ramstate_t : RAM handshake state reported to the memory controller
// -----------------------------------------------------------------------------
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

endpackage

// File: rtl/ram_array.sv
// -----------------------------------------------------------------------------
// ram_array
// DEPTH x 32-bit word storage. Writes are synchronous with a write enable;
// reads go through a registered output that only updates when rd_en is set,
// so the output holds its last read value otherwise.
// Ports:
//   CLK      in  : clock, rising edge
//   nRST     in  : async active-low reset (clears the read register only)
//   wr_en    in  : commit wr_data to wr_idx on this edge
//   wr_idx   in  : write word index
//   wr_data  in  : write data
//   rd_en    in  : load rd_data from rd_idx on this edge
//   rd_idx   in  : read word index
//   rd_data  out : registered read data
// -----------------------------------------------------------------------------
module ram_array
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  word_t            wr_data,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output word_t            rd_data
);

  // Contents are deliberately not reset: they survive nRST.
  word_t mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // A read that lands on the same edge as a write to the same word must see
  // the new data (write visible to the very next access).
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= (wr_en && (wr_idx == rd_idx)) ? wr_data : mem[rd_idx];
    end
  end

endmodule

// File: rtl/ram_latency_model.sv
// -----------------------------------------------------------------------------
// ram_latency_model
// Word-addressed RAM responder with configurable access latency, serving the
// RAM side of the memory controller. Requests wait LAT cycles in BUSY, are
// served in a single ACCESS cycle, and malformed requests report ERROR.
// Parameters:
//   LAT   : wait cycles in BUSY before ACCESS (0..15)
//   DEPTH : number of 32-bit words, power of two
// Ports:
//   CLK      in  : clock, rising edge
//   nRST     in  : async active-low reset
//   ramaddr  in  : byte address of the request
//   ramstore in  : write data
//   ramREN   in  : read request, held until ACCESS
//   ramWEN   in  : write request, held until ACCESS
//   ramload  out : registered read data, valid during a read ACCESS
//   ramstate out : FREE / BUSY / ACCESS / ERROR (the state register)
// -----------------------------------------------------------------------------
module ram_latency_model
  import cpu_types_pkg::*;
#(
  parameter int LAT   = 2,
  parameter int DEPTH = 4096
) (
  input  logic      CLK,
  input  logic      nRST,
  input  word_t     ramaddr,
  input  word_t     ramstore,
  input  logic      ramREN,
  input  logic      ramWEN,
  output word_t     ramload,
  output ramstate_t ramstate
);

  localparam int                CNT_W   = 4;
  localparam int                IDX_W   = $clog2(DEPTH);
  localparam logic [CNT_W-1:0]  LAT_LD  = CNT_W'(LAT);
  localparam word_t             DEPTH_W = 32'(DEPTH);

  ramstate_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  // Latched request, compared against the live inputs while waiting.
  word_t req_addr, req_store;
  logic  req_ren, req_wen;
  logic  latch;

  logic  active, malformed, differs;
  logic  rd_en, wr_en;

  assign active    = ramREN | ramWEN;
  // Upper address bits beyond the storage index only matter for the range test.
  assign malformed = (ramREN & ramWEN)
                   | (ramaddr[1:0] != 2'b00)
                   | ({2'b00, ramaddr[31:2]} >= DEPTH_W);
  // Store data only counts as a change when the request is a write.
  assign differs   = (ramaddr != req_addr)
                   | (ramREN != req_ren)
                   | (ramWEN != req_wen)
                   | (ramWEN & (ramstore != req_store));

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    latch   = 1'b0;
    rd_en   = 1'b0;
    unique case (state)
      BUSY: begin
        if (!active) begin
          state_n = FREE;
        end else if (differs) begin
          // Any change restarts the full latency.
          latch   = 1'b1;
          cnt_n   = LAT_LD;
          state_n = malformed ? ERROR : BUSY;
        end else begin
          cnt_n = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state_n = ACCESS;
            rd_en   = ramREN;
          end
        end
      end
      // FREE, ACCESS and ERROR all choose the next request the same way; a
      // request still held after ACCESS simply starts a new transaction.
      default: begin
        if (!active) begin
          state_n = FREE;
        end else if (malformed) begin
          state_n = ERROR;
        end else if (LAT == 0) begin
          // The request is latched here too so the write committed on the
          // edge leaving ACCESS uses the same address/data that entered it.
          state_n = ACCESS;
          latch   = 1'b1;
          rd_en   = ramREN;
        end else begin
          state_n = BUSY;
          cnt_n   = LAT_LD;
          latch   = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= FREE;
      cnt       <= '0;
      req_addr  <= '0;
      req_store <= '0;
      req_ren   <= 1'b0;
      req_wen   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (latch) begin
        req_addr  <= ramaddr;
        req_store <= ramstore;
        req_ren   <= ramREN;
        req_wen   <= ramWEN;
      end
    end
  end

  // Writes commit on the edge that leaves ACCESS; a reset before that edge
  // drops the state to FREE and so aborts the write.
  assign wr_en = (state == ACCESS) & req_wen;

  ram_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram_array (
    .CLK     (CLK),
    .nRST    (nRST),
    .wr_en   (wr_en),
    .wr_idx  (req_addr[IDX_W+1:2]),
    .wr_data (req_store),
    .rd_en   (rd_en),
    .rd_idx  (ramaddr[IDX_W+1:2]),
    .rd_data (ramload)
  );

  assign ramstate = state;

endmodule

// File: tb/tb_ram_latency_model.sv
// -----------------------------------------------------------------------------
// tb_ram_latency_model
// Scoreboard bench for ram_latency_model. Three instances share the clock and
// reset: LAT=2 (index 0), LAT=0 (index 1) and LAT=3 (index 2). Expected read
// data is pushed when a read is issued and popped when ACCESS is observed.
// -----------------------------------------------------------------------------
module tb_ram_latency_model;
  import cpu_types_pkg::*;

  localparam int DEPTH = 64;
  localparam int NI    = 3;

  logic      clk   = 1'b0;
  logic      rst_n = 1'b0;
  word_t     addr  [NI];
  word_t     store [NI];
  word_t     load  [NI];
  logic      ren   [NI];
  logic      wen   [NI];
  ramstate_t st    [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    ram_latency_model #(
      .LAT   (g == 0 ? 2 : (g == 1 ? 0 : 3)),
      .DEPTH (DEPTH)
    ) u_dut (
      .CLK      (clk),
      .nRST     (rst_n),
      .ramaddr  (addr[g]),
      .ramstore (store[g]),
      .ramREN   (ren[g]),
      .ramWEN   (wen[g]),
      .ramload  (load[g]),
      .ramstate (st[g])
    );
  end

  int    n_checks = 0;
  int    n_pass   = 0;
  word_t model   [NI][DEPTH];
  word_t last_rd [NI];
  word_t exp_q   [$];

  function automatic int lat_of(int g);
    return (g == 0) ? 2 : ((g == 1) ? 0 : 3);
  endfunction

  task automatic check(string tag, word_t got, word_t exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic pop_check(string tag, int g);
    word_t e;
    e = exp_q.pop_front();
    check(tag, load[g], e);
    last_rd[g] = e;
  endtask

  // One full transaction from an idle responder; drops the request as soon
  // as ACCESS is seen, like a well-behaved controller.
  task automatic xact(string tag, int g, bit wr, word_t a, word_t d);
    int off;
    int idx;
    off = -1;
    idx = int'(a >> 2);
    addr[g]  = a;
    store[g] = d;
    ren[g]   = !wr;
    wen[g]   = wr;
    if (!wr) exp_q.push_back(model[g][idx]);
    for (int j = 0; j <= lat_of(g) + 4; j++) begin
      @(negedge clk);
      if (st[g] == ACCESS) begin
        off = j;
        break;
      end
      check({tag, "_state"}, 32'(st[g]), (j == 0) ? 32'(FREE) : 32'(BUSY));
    end
    check({tag, "_lat"}, 32'(off), 32'(lat_of(g) + 1));
    if (wr) begin
      if (off >= 0) model[g][idx] = d;
    end else if (off >= 0) begin
      pop_check({tag, "_data"}, g);
    end else begin
      void'(exp_q.pop_front());
    end
    ren[g] = 1'b0;
    wen[g] = 1'b0;
    @(posedge clk); #1;
  endtask

  logic  err_ren [3] = '{1'b1, 1'b0, 1'b0};
  word_t err_adr [3] = '{32'h10, 32'h2, 32'(4 * DEPTH)};

  initial begin
    int off;
    for (int g = 0; g < NI; g++) begin
      addr[g] = '0; store[g] = '0; ren[g] = 1'b0; wen[g] = 1'b0; last_rd[g] = '0;
    end
    #12;
    for (int g = 0; g < NI; g++) begin
      check("rst_state", 32'(st[g]), 32'(FREE));
      check("rst_load", load[g], 32'h0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // LAT=2: write then read
    xact("w0_init", 0, 1'b1, 32'h0,  32'h0F0F0F0F);
    xact("w10",     0, 1'b1, 32'h10, 32'hDEADBEEF);
    xact("r10",     0, 1'b0, 32'h10, 32'h0);

    // LAT=2: write dropped after one BUSY cycle has no effect
    xact("w30_old", 0, 1'b1, 32'h30, 32'h01234567);
    addr[0] = 32'h30; store[0] = 32'hCAFEF00D; wen[0] = 1'b1;
    @(negedge clk); check("drop_free0", 32'(st[0]), 32'(FREE));
    @(negedge clk); check("drop_busy", 32'(st[0]), 32'(BUSY));
    wen[0] = 1'b0;
    @(negedge clk); check("drop_free", 32'(st[0]), 32'(FREE));
    @(posedge clk); #1;
    xact("r30", 0, 1'b0, 32'h30, 32'h0);

    // Malformed requests: ERROR while held, FREE one edge after the drop
    for (int c = 0; c < 3; c++) begin
      addr[0] = err_adr[c]; store[0] = 32'hBADC0DE5; ren[0] = err_ren[c]; wen[0] = 1'b1;
      @(negedge clk); check("err_free0", 32'(st[0]), 32'(FREE));
      @(negedge clk); check("err_state", 32'(st[0]), 32'(ERROR));
      @(negedge clk); check("err_hold", 32'(st[0]), 32'(ERROR));
      ren[0] = 1'b0; wen[0] = 1'b0;
      @(negedge clk); check("err_exit", 32'(st[0]), 32'(FREE));
      check("err_load", load[0], last_rd[0]);
      @(posedge clk); #1;
    end
    xact("err_r10", 0, 1'b0, 32'h10, 32'h0);
    xact("err_r0",  0, 1'b0, 32'h0,  32'h0);

    // LAT=0: held read gives ACCESS on consecutive cycles
    xact("l0_w0", 1, 1'b1, 32'h0, 32'h11111111);
    addr[1] = 32'h0; ren[1] = 1'b1;
    exp_q.push_back(model[1][0]);
    exp_q.push_back(model[1][0]);
    @(negedge clk); check("b2b_free", 32'(st[1]), 32'(FREE));
    @(negedge clk); check("b2b_acc1", 32'(st[1]), 32'(ACCESS)); pop_check("b2b_data1", 1);
    @(negedge clk); check("b2b_acc2", 32'(st[1]), 32'(ACCESS)); pop_check("b2b_data2", 1);
    ren[1] = 1'b0;
    @(negedge clk); check("b2b_end", 32'(st[1]), 32'(FREE));
    @(posedge clk); #1;

    // LAT=3: address change mid-BUSY restarts the latency
    xact("l3_w20", 2, 1'b1, 32'h20, 32'hA8A8A8A8);
    xact("l3_w24", 2, 1'b1, 32'h24, 32'h9B9B9B9B);
    addr[2] = 32'h20; ren[2] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    addr[2] = 32'h24;
    exp_q.push_back(model[2][9]);
    off = -1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (st[2] == ACCESS) begin
        off = j;
        break;
      end
      check("rst_busy", 32'(st[2]), 32'(BUSY));
    end
    check("restart_lat", 32'(off), 32'd4);
    if (off >= 0) pop_check("restart_data", 2);
    else void'(exp_q.pop_front());
    ren[2] = 1'b0;
    @(posedge clk); #1;

    // Async reset while BUSY
    addr[0] = 32'h10; ren[0] = 1'b1;
    @(negedge clk);
    @(negedge clk); check("ar_busy", 32'(st[0]), 32'(BUSY));
    #2 rst_n = 1'b0;
    #1;
    for (int g = 0; g < NI; g++) begin
      check("ar_state", 32'(st[g]), 32'(FREE));
      check("ar_load", load[g], 32'h0);
      last_rd[g] = '0;
    end
    ren[0] = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    xact("ar_r10", 0, 1'b0, 32'h10, 32'h0);
    xact("ar_r24", 2, 1'b0, 32'h24, 32'h0);
    xact("ar_r0",  1, 1'b0, 32'h0,  32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation did not finish");
  end

endmodule
